branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Sequences the decode-stage jump/branch resolver of the DLX pipeline: stalls ID while the
//  branch operand (rs1) is still in flight, issues the PC redirect and IF/ID flush on a taken
//  jump/branch, and shares the single register-file write port between WB and jal link writes.
//  Sits between the resolver, hazard sources (EX/MEM/WB) and the PC / IF/ID registers.
// PARAMETERS
//  DATA_W    32  width of PC, target and write data
//  LINK_REG  31  register number written by jal
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  id_valid       in   1       ID holds a real (non-bubble) instruction
//  id_is_jump     in   1       ID opcode is j/jal/jr/beqz/bnez
//  id_is_jal      in   1       ID opcode is jal
//  id_uses_rs1    in   1       ID opcode reads rs1 (jr/beqz/bnez)
//  id_rs1         in   5       rs1 field of ID instruction
//  take_branch    in   1       resolver decision for ID instruction
//  target_pc      in   DATA_W  resolver target PC
//  id_pc_plus_four in  DATA_W  PC+4 of ID instruction (link value)
//  ex_wen/ex_rd   in   1/5     EX-stage instruction writes ex_rd
//  mem_load/mem_rd in  1/5     MEM-stage load writes mem_rd
//  wb_wen/wb_rd/wb_data in 1/5/DATA_W  WB-stage write request
//  stall          out  1       hold PC and IF/ID this cycle
//  pc_sel         out  1       1: PC <= pc_redirect
//  pc_redirect    out  DATA_W  redirect target
//  if_id_flush    out  1       replace IF/ID contents with bubble
//  rf_wen/rf_wsel/rf_din out 1/5/DATA_W  register-file write port
//  link_pending   out  1       deferred link write buffered
// BEHAVIOUR
//  - Reset: state=IDLE, link buffer cleared; stall, pc_sel, if_id_flush, rf_wen, link_pending = 0;
//    pc_redirect, rf_din = 0; rf_wsel = 0. Reset mid-stall or with link pending drops all state.
//  - hazard (comb) = id_valid & id_is_jump & [ id_uses_rs1 & id_rs1!=0 & ((ex_wen & ex_rd==id_rs1)
//    | (mem_load & mem_rd==id_rs1) | (link_pending & id_rs1==LINK_REG))
//    | (id_is_jal & link_pending) ].
//  - FSM: IDLE -> STALL on hazard; STALL stays while hazard, -> IDLE when clear.
//    stall = hazard (comb, both states). resolve = id_valid & id_is_jump & ~hazard & state!=REDIRECT.
//  - resolve & take_branch: same cycle pc_sel=1, pc_redirect=target_pc, if_id_flush=1; next state
//    REDIRECT for exactly 1 cycle, during which ID is the flushed bubble: id_valid ignored, no
//    stall, no redirect. REDIRECT -> IDLE (or STALL if hazard then).
//  - Not taken / non-jump: pc_sel=0, if_id_flush=0; zero-cycle added latency.
//  - Write port: WB has priority. rf_wen=wb_wen, rf_wsel=wb_rd, rf_din=wb_data when wb_wen.
//    Link write on resolve & id_is_jal: if ~wb_wen and ~link_pending -> direct same cycle
//    (rf_wsel=LINK_REG, rf_din=id_pc_plus_four); if wb_wen -> captured into 1-entry buffer,
//    link_pending=1 from next cycle. Buffer drains first cycle with ~wb_wen; link_pending clears
//    the cycle after drain. Second jal while pending is held off by hazard (never lost/overwritten).
//  - Simultaneous hazard and take_branch: hazard wins; no redirect until hazard clears.
//  - Outputs pc_sel/pc_redirect/if_id_flush/stall/rf_* combinational from state+inputs;
//    link buffer and state registered.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds outputs stat_taken[31:0] (+1 per cycle with pc_sel) and
//    stat_stall[31:0] (+1 per cycle with stall); both zero on reset, wrap at 2^32.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  - reset held 2 cycles with WB/link activity -> all outputs 0, state IDLE, link_pending=0.
//  - beqz r5 taken, ex_wen=1 ex_rd=5 for 1 cycle then mem_load=1 mem_rd=5 1 cycle -> stall=1 for
//    2 cycles, then pc_sel=1 pc_redirect=0x0000_0040 if_id_flush=1 for 1 cycle.
//  - j taken target 0x100, next cycle id_valid=1 id_is_jump=1 take_branch=1 -> only one redirect
//    (0x100); REDIRECT cycle has pc_sel=0.
//  - jal pc+4=0x24 with wb_wen=1 wb_rd=3 -> rf writes r3 that cycle; next cycle (wb_wen=0)
//    rf_wen=1 rf_wsel=31 rf_din=0x24; link_pending high for 1 cycle.
//  - jal while link_pending, and jr r31 while link_pending -> stall until drain, then resolve.
//  - BRANCH_STATS_EN build: 3 taken branches, 4 stall cycles -> stat_taken=3, stat_stall=4.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Decode-stage jump/branch sequencer: rs1 hazard stall, PC redirect + IF/ID flush, and
// register-file write-port sharing between WB and jal link writes. Optional: BRANCH_STATS_EN.
module branch_redirect_ctrl #(
   parameter int         DATA_W   = 32,
   parameter logic [4:0] LINK_REG = 5'd31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic              id_is_jump,
   input  logic              id_is_jal,
   input  logic              id_uses_rs1,
   input  logic [4:0]        id_rs1,
   input  logic              take_branch,
   input  logic [DATA_W-1:0] target_pc,
   input  logic [DATA_W-1:0] id_pc_plus_four,
   input  logic              ex_wen,
   input  logic [4:0]        ex_rd,
   input  logic              mem_load,
   input  logic [4:0]        mem_rd,
   input  logic              wb_wen,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              pc_sel,
   output logic [DATA_W-1:0] pc_redirect,
   output logic              if_id_flush,
   output logic              rf_wen,
   output logic [4:0]        rf_wsel,
   output logic [DATA_W-1:0] rf_din,
   output logic              link_pending
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]       stat_taken,
   output logic [31:0]       stat_stall
`endif
);

   // state    | meaning
   // IDLE     | no hazard held, ID resolves normally
   // STALL    | ID jump waiting on rs1 or on the link buffer
   // REDIRECT | ID holds the flushed bubble after a taken jump
   typedef enum logic [1:0] {S_IDLE, S_STALL, S_REDIRECT} state_t;

   state_t            state, state_nxt;
   logic              link_pending_q;
   logic [DATA_W-1:0] link_data_q;

   logic id_v, rs1_hit, hazard, resolve, redirect, link_req, drain;

   // ID contents are a bubble in REDIRECT, and nothing is seen while reset is asserted
   assign id_v     = id_valid & ~reset & (state != S_REDIRECT);
   assign rs1_hit  = id_uses_rs1 & (id_rs1 != 5'd0) &
                     ((ex_wen & (ex_rd == id_rs1)) |
                      (mem_load & (mem_rd == id_rs1)) |
                      (link_pending_q & (id_rs1 == LINK_REG)));
   assign hazard   = id_v & id_is_jump & (rs1_hit | (id_is_jal & link_pending_q));
   assign resolve  = id_v & id_is_jump & ~hazard;
   assign redirect = resolve & take_branch;
   assign link_req = resolve & id_is_jal;
   assign drain    = link_pending_q & ~wb_wen & ~reset;

   assign link_pending = link_pending_q & ~reset;

   always_comb begin
      state_nxt   = state;
      stall       = hazard;
      pc_sel      = redirect;
      if_id_flush = redirect;
      pc_redirect = '0;
      rf_wen      = 1'b0;
      rf_wsel     = 5'd0;
      rf_din      = '0;

      case (state)
         S_IDLE:     if (hazard) state_nxt = S_STALL;
         S_STALL:    if (!hazard) state_nxt = S_IDLE;
         S_REDIRECT: state_nxt = hazard ? S_STALL : S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
      if (redirect) begin
         state_nxt   = S_REDIRECT;
         pc_redirect = target_pc;
      end

      // WB owns the port; the buffered link drains before any new direct link write
      if (!reset) begin
         if (wb_wen) begin
            rf_wen  = 1'b1;
            rf_wsel = wb_rd;
            rf_din  = wb_data;
         end else if (drain) begin
            rf_wen  = 1'b1;
            rf_wsel = LINK_REG;
            rf_din  = link_data_q;
         end else if (link_req) begin
            rf_wen  = 1'b1;
            rf_wsel = LINK_REG;
            rf_din  = id_pc_plus_four;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         link_pending_q <= 1'b0;
         link_data_q    <= '0;
      end else begin
         state <= state_nxt;
         if (link_req && wb_wen) begin
            link_pending_q <= 1'b1;
            link_data_q    <= id_pc_plus_four;
         end else if (drain) begin
            link_pending_q <= 1'b0;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_taken <= '0;
         stat_stall <= '0;
      end else begin
         if (pc_sel) stat_taken <= stat_taken + 32'd1;
         if (stall)  stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl; stats checks only when BRANCH_STATS_EN.
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_valid, id_is_jump, id_is_jal, id_uses_rs1, take_branch;
   logic [4:0]  id_rs1, ex_rd, mem_rd, wb_rd;
   logic [31:0] target_pc, id_pc_plus_four, wb_data;
   logic        ex_wen, mem_load, wb_wen;
   logic        stall, pc_sel, if_id_flush, rf_wen, link_pending;
   logic [31:0] pc_redirect, rf_din;
   logic [4:0]  rf_wsel;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_taken, stat_stall;
`endif

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.DATA_W(32), .LINK_REG(5'd31)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_is_jump(id_is_jump), .id_is_jal(id_is_jal),
      .id_uses_rs1(id_uses_rs1), .id_rs1(id_rs1), .take_branch(take_branch),
      .target_pc(target_pc), .id_pc_plus_four(id_pc_plus_four),
      .ex_wen(ex_wen), .ex_rd(ex_rd), .mem_load(mem_load), .mem_rd(mem_rd),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .pc_sel(pc_sel), .pc_redirect(pc_redirect),
      .if_id_flush(if_id_flush), .rf_wen(rf_wen), .rf_wsel(rf_wsel),
      .rf_din(rf_din), .link_pending(link_pending)
`ifdef BRANCH_STATS_EN
      , .stat_taken(stat_taken), .stat_stall(stat_stall)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_in();
      id_valid = 0; id_is_jump = 0; id_is_jal = 0; id_uses_rs1 = 0; take_branch = 0;
      id_rs1 = 0; target_pc = 0; id_pc_plus_four = 0;
      ex_wen = 0; ex_rd = 0; mem_load = 0; mem_rd = 0;
      wb_wen = 0; wb_rd = 0; wb_data = 0;
   endtask

   // move to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_jal(input logic [31:0] pc4, input logic [31:0] tgt);
      id_valid = 1; id_is_jump = 1; id_is_jal = 1; id_uses_rs1 = 0; id_rs1 = 0;
      take_branch = 1; target_pc = tgt; id_pc_plus_four = pc4;
   endtask

   task automatic chk_ctl(input string tag, input logic st, input logic ps,
                          input logic [31:0] pr, input logic fl);
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
      chk({tag, ".pc_sel"}, {31'd0, pc_sel}, {31'd0, ps});
      chk({tag, ".pc_redirect"}, pc_redirect, pr);
      chk({tag, ".flush"}, {31'd0, if_id_flush}, {31'd0, fl});
   endtask

   task automatic chk_rf(input string tag, input logic we, input logic [4:0] sel,
                         input logic [31:0] din, input logic lp);
      chk({tag, ".rf_wen"}, {31'd0, rf_wen}, {31'd0, we});
      chk({tag, ".rf_wsel"}, {27'd0, rf_wsel}, {27'd0, sel});
      chk({tag, ".rf_din"}, rf_din, din);
      chk({tag, ".link_pending"}, {31'd0, link_pending}, {31'd0, lp});
   endtask

   initial begin
      // reset held with WB and jal activity
      clear_in();
      set_jal(32'h24, 32'h80);
      wb_wen = 1; wb_rd = 5'd3; wb_data = 32'hAA;
      #2;
      chk_ctl("rst0", 0, 0, 0, 0);
      chk_rf("rst0", 0, 0, 0, 0);
      step();
      chk_ctl("rst1", 0, 0, 0, 0);
      chk_rf("rst1", 0, 0, 0, 0);
      step();
      reset = 0;
      clear_in();
      #1;
      chk_ctl("post_rst", 0, 0, 0, 0);
      chk_rf("post_rst", 0, 0, 0, 0);

      // beqz r5 taken: EX hazard, then MEM load hazard, then redirect
      step();
      id_valid = 1; id_is_jump = 1; id_uses_rs1 = 1; id_rs1 = 5'd5;
      take_branch = 1; target_pc = 32'h40;
      ex_wen = 1; ex_rd = 5'd5;
      #1 chk_ctl("beqz_ex", 1, 0, 0, 0);
      step();
      ex_wen = 0; mem_load = 1; mem_rd = 5'd5;
      #1 chk_ctl("beqz_mem", 1, 0, 0, 0);
      step();
      mem_load = 0;
      #1 chk_ctl("beqz_go", 0, 1, 32'h40, 1);
      step();
      ex_wen = 1; ex_rd = 5'd5;   // bubble cycle: ID contents ignored
      #1 chk_ctl("beqz_bubble", 0, 0, 0, 0);
      step();
      clear_in();
      #1 chk_ctl("beqz_done", 0, 0, 0, 0);

      // j taken 0x100 followed by another taken jump in the bubble slot
      step();
      id_valid = 1; id_is_jump = 1; take_branch = 1; target_pc = 32'h100;
      #1 chk_ctl("j_go", 0, 1, 32'h100, 1);
      step();
      target_pc = 32'h200;
      #1 chk_ctl("j_bubble", 0, 0, 0, 0);
      step();
      clear_in();

      // not-taken jump and non-jump with matching EX write: no stall, no redirect
      id_valid = 1; id_is_jump = 1; id_uses_rs1 = 1; id_rs1 = 5'd7; target_pc = 32'h300;
      #1 chk_ctl("nt", 0, 0, 0, 0);
      step();
      id_is_jump = 0; take_branch = 1; ex_wen = 1; ex_rd = 5'd7;
      #1 chk_ctl("nonjump", 0, 0, 0, 0);
      step();
      id_is_jump = 1; id_rs1 = 5'd0; ex_rd = 5'd0; target_pc = 32'h500;
      #1 chk_ctl("r0_nohaz", 0, 1, 32'h500, 1);
      step();
      clear_in();
      step();

      // jal with WB busy: deferred link write
      set_jal(32'h24, 32'h800);
      wb_wen = 1; wb_rd = 5'd3; wb_data = 32'hAA;
      #1;
      chk_ctl("jal_wb", 0, 1, 32'h800, 1);
      chk_rf("jal_wb", 1, 5'd3, 32'hAA, 0);
      step();
      clear_in();
      #1 chk_rf("jal_drain", 1, 5'd31, 32'h24, 1);
      step();
      #1 chk_rf("jal_after", 0, 0, 0, 0);

      // jal with WB idle: direct link write
      step();
      set_jal(32'h34, 32'h900);
      #1 chk_rf("jal_direct", 1, 5'd31, 32'h34, 0);
      step();
      clear_in();
      #1 chk_rf("jal_direct_after", 0, 0, 0, 0);

      // second jal while link pending is held until drain
      step();
      set_jal(32'h50, 32'hA00);
      wb_wen = 1; wb_rd = 5'd4; wb_data = 32'h11;
      step();
      clear_in();
      wb_wen = 1; wb_rd = 5'd4; wb_data = 32'h12;
      #1 chk_rf("jal2_pend", 1, 5'd4, 32'h12, 1);
      step();
      set_jal(32'h60, 32'hB00);
      wb_wen = 1; wb_rd = 5'd6; wb_data = 32'h13;
      #1;
      chk_ctl("jal2_hold", 1, 0, 0, 0);
      chk_rf("jal2_hold", 1, 5'd6, 32'h13, 1);
      step();
      wb_wen = 0;
      #1;
      chk_ctl("jal2_drain", 1, 0, 0, 0);
      chk_rf("jal2_drain", 1, 5'd31, 32'h50, 1);
      step();
      #1;
      chk_ctl("jal2_go", 0, 1, 32'hB00, 1);
      chk_rf("jal2_go", 1, 5'd31, 32'h60, 0);
      step();
      clear_in();

      // jr r31 while link pending
      step();
      set_jal(32'h70, 32'hC00);
      wb_wen = 1; wb_rd = 5'd2; wb_data = 32'h21;
      step();
      clear_in();
      wb_wen = 1; wb_rd = 5'd2; wb_data = 32'h22;
      step();
      id_valid = 1; id_is_jump = 1; id_uses_rs1 = 1; id_rs1 = 5'd31;
      take_branch = 1; target_pc = 32'h300;
      #1 chk_ctl("jr_hold", 1, 0, 0, 0);
      step();
      wb_wen = 0;
      #1;
      chk_ctl("jr_drain", 1, 0, 0, 0);
      chk_rf("jr_drain", 1, 5'd31, 32'h70, 1);
      step();
      #1;
      chk_ctl("jr_go", 0, 1, 32'h300, 1);
      chk_rf("jr_go", 0, 0, 0, 0);
      step();
      clear_in();

`ifdef BRANCH_STATS_EN
      reset = 1;
      step();
      step();
      reset = 0;
      #1;
      chk("stat_taken_rst", stat_taken, 32'd0);
      chk("stat_stall_rst", stat_stall, 32'd0);
      id_valid = 1; id_is_jump = 1; id_uses_rs1 = 1; id_rs1 = 5'd9;
      take_branch = 1; target_pc = 32'h40; ex_wen = 1; ex_rd = 5'd9;
      repeat (4) step();
      ex_wen = 0;
      step();                      // taken 1
      id_uses_rs1 = 0; id_rs1 = 0;
      step();                      // bubble
      step();                      // taken 2
      step();                      // bubble
      step();                      // taken 3
      clear_in();
      #1;
      chk("stat_taken", stat_taken, 32'd3);
      chk("stat_stall", stat_stall, 32'd4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
